// File: rtl/cache_block_fill.sv
// -----------------------------------------------------------------------------
// cache_block_fill
//
// Memory-side fill engine placed directly behind the cache. It takes the
// cache's propagated requests. A read fetches the whole aligned block one word
// at a time over a word-wide valid/ready memory port. The words are assembled
// into a buffer and the finished block is returned with a one-cycle ram_valid
// pulse. A write is forwarded to memory as a single-word write.
//
// Ports
//   clk, reset        clock (posedge) and synchronous active-high reset
//   req_address       request word address
//   req_read_en       block fill request (level, held by the cache on a miss)
//   req_write_data    write word
//   req_write_en      single-word write request (level)
//   ram_valid         one-cycle pulse: ram_data holds a complete block
//   ram_data          assembled block, index = word offset within the block
//   busy              high whenever the engine is not idle
//   mem_req_valid     memory request valid
//   mem_req_ready     memory accepts the request this cycle
//   mem_address       memory word address
//   mem_write_en      1 = write request, 0 = read request
//   mem_write_data    write word
//   mem_rvalid        read response valid (responses return in request order)
//   mem_rdata         read response word
// -----------------------------------------------------------------------------
module cache_block_fill #(
    parameter int RAM_ADDRESS_BITS = 10,
    parameter int DATA_BITS        = 32,
    parameter int BLOCK_BITS       = 2,
    parameter int COOLDOWN_CYCLES  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [RAM_ADDRESS_BITS-1:0] req_address,
    input  logic                        req_read_en,
    input  logic [DATA_BITS-1:0]        req_write_data,
    input  logic                        req_write_en,
    output logic                        ram_valid,
    output logic [DATA_BITS-1:0]        ram_data [2**BLOCK_BITS],
    output logic                        busy,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [RAM_ADDRESS_BITS-1:0] mem_address,
    output logic                        mem_write_en,
    output logic [DATA_BITS-1:0]        mem_write_data,
    input  logic                        mem_rvalid,
    input  logic [DATA_BITS-1:0]        mem_rdata
);

    localparam int BLOCK_SIZE = 2**BLOCK_BITS;
    localparam int CNT_W      = BLOCK_BITS + 1;
    localparam int TAG_W      = RAM_ADDRESS_BITS - BLOCK_BITS;
    localparam int CD_W       = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

    localparam logic [CNT_W-1:0] BLOCK_SIZE_C = CNT_W'(BLOCK_SIZE);
    localparam logic [CNT_W-1:0] LAST_WORD    = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [CD_W-1:0]  COOL_LAST    =
        CD_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        FILL,
        DONE,
        COOLDOWN
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       issue_cnt;
    logic [CNT_W-1:0]       recv_cnt;
    logic [TAG_W-1:0]       base_tag;
    logic [CD_W-1:0]        cool_cnt;
    logic [DATA_BITS-1:0]   buffer [BLOCK_SIZE];

    logic                   xfer;
    logic [CNT_W-1:0]       issue_next;
    logic [BLOCK_BITS-1:0]  recv_idx;

    assign xfer       = mem_req_valid & mem_req_ready;
    assign issue_next = issue_cnt + CNT_W'(1);
    assign recv_idx   = recv_cnt[BLOCK_BITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            issue_cnt      <= '0;
            recv_cnt       <= '0;
            base_tag       <= '0;
            cool_cnt       <= '0;
            ram_valid      <= 1'b0;
            busy           <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_address    <= '0;
            mem_write_en   <= 1'b0;
            mem_write_data <= '0;
            // NOTE: the block buffer is reset on purpose so that a fill aborted
            // by reset leaves no partial block behind; a plain data RAM would
            // normally be left unreset.
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                buffer[i]   <= '0;
                ram_data[i] <= '0;
            end
        end else begin
            // NOTE: all state updates use non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    // Any response still in flight from an aborted fill is
                    // simply dropped here.
                    if (req_write_en) begin
                        state          <= WRITE;
                        busy           <= 1'b1;
                        mem_req_valid  <= 1'b1;
                        mem_write_en   <= 1'b1;
                        mem_address    <= req_address;
                        mem_write_data <= req_write_data;
                    end else if (req_read_en) begin
                        state         <= FILL;
                        busy          <= 1'b1;
                        base_tag      <= req_address[RAM_ADDRESS_BITS-1:BLOCK_BITS];
                        issue_cnt     <= '0;
                        recv_cnt      <= '0;
                        mem_req_valid <= 1'b1;
                        mem_write_en  <= 1'b0;
                        mem_address   <= {req_address[RAM_ADDRESS_BITS-1:BLOCK_BITS],
                                          {BLOCK_BITS{1'b0}}};
                    end
                end

                WRITE: begin
                    if (xfer) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        mem_req_valid <= 1'b0;
                        mem_write_en  <= 1'b0;
                    end
                end

                FILL: begin
                    // Issue side: the offset field is replaced rather than
                    // added to, so the address never leaves the block.
                    if (xfer) begin
                        issue_cnt <= issue_next;
                        if (issue_next < BLOCK_SIZE_C) begin
                            mem_address <= {base_tag, issue_next[BLOCK_BITS-1:0]};
                        end else begin
                            mem_req_valid <= 1'b0;
                        end
                    end
                    // Receive side: runs independently of issue; the last word
                    // is merged straight into ram_data so the pulse lands on
                    // the cycle after it arrives.
                    if (mem_rvalid) begin
                        buffer[recv_idx] <= mem_rdata;
                        recv_cnt         <= recv_cnt + CNT_W'(1);
                        if (recv_cnt == LAST_WORD) begin
                            state     <= DONE;
                            ram_valid <= 1'b1;
                            for (int i = 0; i < BLOCK_SIZE; i++) begin
                                ram_data[i] <= (CNT_W'(i) == recv_cnt) ? mem_rdata
                                                                       : buffer[i];
                            end
                        end
                    end
                end

                DONE: begin
                    ram_valid <= 1'b0;
                    cool_cnt  <= '0;
                    if (COOLDOWN_CYCLES == 0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= COOLDOWN;
                    end
                end

                COOLDOWN: begin
                    // Requests are ignored here so the cache's still-held miss
                    // does not start a second fill of the same block.
                    if (cool_cnt == COOL_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cool_cnt <= cool_cnt + CD_W'(1);
                    end
                end

                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    ram_valid     <= 1'b0;
                    mem_req_valid <= 1'b0;
                    mem_write_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_block_fill.sv
// -----------------------------------------------------------------------------
// tb_cache_block_fill
//
// Directed bench for cache_block_fill with default parameters. A memory model
// process logs every handshake, checks that stalled requests stay stable, and
// returns addr+0x1000 one cycle after each read transfer (unless a scenario
// drives responses by hand). Each scenario task applies its stimulus and
// compares the logs and outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_cache_block_fill;

    logic        clk;
    logic        reset;
    logic [9:0]  req_address;
    logic        req_read_en;
    logic [31:0] req_write_data;
    logic        req_write_en;
    logic        ram_valid;
    logic [31:0] ram_data [4];
    logic        busy;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [9:0]  mem_address;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Memory-model state and transfer logs.
    bit          auto_resp    = 1'b1;
    bit          toggle_ready = 1'b0;
    int          stab_err     = 0;
    bit          prev_stall   = 1'b0;
    logic [9:0]  p_addr;
    logic        p_we;
    logic [31:0] p_data;
    logic [9:0]  pend [$];
    logic [9:0]  xa [$];
    logic        xw [$];
    logic [31:0] xd [$];
    int          xc [$];
    int          rv_c [$];
    logic [31:0] rv_d [4];

    cache_block_fill dut (
        .clk            (clk),
        .reset          (reset),
        .req_address    (req_address),
        .req_read_en    (req_read_en),
        .req_write_data (req_write_data),
        .req_write_en   (req_write_en),
        .ram_valid      (ram_valid),
        .ram_data       (ram_data),
        .busy           (busy),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_address    (mem_address),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: observe at negedge, drive responses 1 ns after posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready) begin
                xa.push_back(mem_address);
                xw.push_back(mem_write_en);
                xd.push_back(mem_write_data);
                xc.push_back(cyc);
                if (!mem_write_en) pend.push_back(mem_address);
            end
            if (prev_stall && !reset &&
                (!mem_req_valid || mem_address !== p_addr ||
                 mem_write_en !== p_we || mem_write_data !== p_data))
                stab_err++;
            prev_stall = mem_req_valid && !mem_req_ready;
            p_addr = mem_address;
            p_we   = mem_write_en;
            p_data = mem_write_data;
            if (ram_valid) begin
                rv_c.push_back(cyc);
                for (int i = 0; i < 4; i++) rv_d[i] = ram_data[i];
            end
            @(posedge clk);
            #1;
            if (toggle_ready) mem_req_ready = ~mem_req_ready;
            if (auto_resp) begin
                if (pend.size() > 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = {22'b0, pend.pop_front()} + 32'h1000;
                end else begin
                    mem_rvalid = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        xa.delete(); xw.delete(); xd.delete(); xc.delete(); rv_c.delete();
        for (int i = 0; i < 4; i++) rv_d[i] = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        vectors++; if (ram_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ram_valid: got %b expected 0", ram_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req_valid: got %b expected 0", mem_req_valid); end
        vectors++; if (mem_address !== 10'h000) begin miscompares++; $display("FAIL reset_mem_address: got %h expected 000", mem_address); end
        vectors++; if (mem_write_en !== 1'b0) begin miscompares++; $display("FAIL reset_mem_write_en: got %b expected 0", mem_write_en); end
        vectors++; if (mem_write_data !== 32'h0) begin miscompares++; $display("FAIL reset_mem_write_data: got %h expected 0", mem_write_data); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (ram_data[i] !== 32'h0) begin miscompares++; $display("FAIL reset_ram_data[%0d]: got %h expected 0", i, ram_data[i]); end
        end
        reset = 1'b0;
        tick(2);
        vectors++; if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset: got busy=%b valid=%b expected 0/0", busy, mem_req_valid); end
    endtask

    task automatic test_read_fill();
        int k;
        clear_logs();
        mem_req_ready = 1'b1;
        req_address = 10'h0B7; req_read_en = 1'b1; k = cyc;
        tick(1); req_read_en = 1'b0;
        tick(12);
        vectors++; if (xa.size() != 4) begin miscompares++; $display("FAIL fill_xfer_count: got %0d expected 4", xa.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [9:0] ea;
            ea = 10'h0B4 + 10'(i);
            vectors++; if (xa.size() <= i || xa[i] !== ea || xw[i] !== 1'b0) begin miscompares++; $display("FAIL fill_addr[%0d]: got %h expected %h (read)", i, (xa.size() > i) ? xa[i] : 10'h3FF, ea); end
            vectors++; if (xc.size() <= i || xc[i] != k + 1 + i) begin miscompares++; $display("FAIL fill_issue_cycle[%0d]: got %0d expected %0d", i, (xc.size() > i) ? xc[i] - k : -1, 1 + i); end
            vectors++; if (rv_d[i] !== 32'h10B4 + i) begin miscompares++; $display("FAIL fill_ram_data[%0d]: got %h expected %h", i, rv_d[i], 32'h10B4 + i); end
        end
        vectors++; if (rv_c.size() != 1 || rv_c[0] != k + 6) begin miscompares++; $display("FAIL fill_ram_valid: got %0d pulses first at +%0d expected 1 at +6", rv_c.size(), (rv_c.size() > 0) ? rv_c[0] - k : -1); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL fill_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_ready_toggle();
        clear_logs();
        stab_err = 0;
        mem_req_ready = 1'b0; toggle_ready = 1'b1;
        req_address = 10'h0B7; req_read_en = 1'b1;
        tick(1); req_read_en = 1'b0;
        tick(20);
        toggle_ready = 1'b0; mem_req_ready = 1'b1;
        tick(1);
        vectors++; if (xa.size() != 4) begin miscompares++; $display("FAIL toggle_xfer_count: got %0d expected 4", xa.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [9:0] ea;
            ea = 10'h0B4 + 10'(i);
            vectors++; if (xa.size() <= i || xa[i] !== ea) begin miscompares++; $display("FAIL toggle_addr[%0d]: got %h expected %h", i, (xa.size() > i) ? xa[i] : 10'h3FF, ea); end
            vectors++; if (rv_d[i] !== 32'h10B4 + i) begin miscompares++; $display("FAIL toggle_ram_data[%0d]: got %h expected %h", i, rv_d[i], 32'h10B4 + i); end
        end
        vectors++; if (stab_err != 0) begin miscompares++; $display("FAIL toggle_hold_stable: got %0d unstable stalls expected 0", stab_err); end
        vectors++; if (rv_c.size() != 1) begin miscompares++; $display("FAIL toggle_ram_valid: got %0d pulses expected 1", rv_c.size()); end
    endtask

    task automatic test_write();
        int k;
        clear_logs();
        req_address = 10'h123; req_write_data = 32'hDEADBEEF; req_write_en = 1'b1; k = cyc;
        tick(1); req_write_en = 1'b0;
        vectors++; if (busy !== 1'b1 || mem_req_valid !== 1'b1 || mem_write_en !== 1'b1) begin miscompares++; $display("FAIL write_active: got busy=%b valid=%b we=%b expected 1/1/1", busy, mem_req_valid, mem_write_en); end
        tick(1);
        vectors++; if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL write_release: got busy=%b valid=%b expected 0/0", busy, mem_req_valid); end
        tick(3);
        vectors++; if (xa.size() != 1 || xa[0] !== 10'h123 || xw[0] !== 1'b1 || xd[0] !== 32'hDEADBEEF || xc[0] != k + 1) begin miscompares++; $display("FAIL write_xfer: got %0d xfers addr=%h data=%h expected 1 write 123 DEADBEEF", xa.size(), (xa.size() > 0) ? xa[0] : 10'h3FF, (xd.size() > 0) ? xd[0] : 32'h0); end
        vectors++; if (rv_c.size() != 0) begin miscompares++; $display("FAIL write_no_ram_valid: got %0d pulses expected 0", rv_c.size()); end
        vectors++; if (ram_data[0] !== 32'h10B4 || ram_data[3] !== 32'h10B7) begin miscompares++; $display("FAIL write_ram_data_kept: got %h/%h expected 10b4/10b7", ram_data[0], ram_data[3]); end
    endtask

    task automatic test_held_read();
        clear_logs();
        req_address = 10'h3FE; req_read_en = 1'b1;
        tick(8);
        tick(1); req_read_en = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL held_busy_idle: got %b expected 0", busy); end
        tick(10);
        vectors++; if (xa.size() != 4) begin miscompares++; $display("FAIL held_xfer_count: got %0d expected 4", xa.size()); end
        vectors++; if (rv_c.size() != 1) begin miscompares++; $display("FAIL held_ram_valid: got %0d pulses expected 1", rv_c.size()); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (rv_d[i] !== 32'h13FC + i) begin miscompares++; $display("FAIL held_ram_data[%0d]: got %h expected %h", i, rv_d[i], 32'h13FC + i); end
        end
    endtask

    task automatic test_reset_mid_fill();
        int k;
        clear_logs();
        auto_resp = 1'b0; mem_rvalid = 1'b0;
        req_address = 10'h2A1; req_read_en = 1'b1;
        tick(1); req_read_en = 1'b0;
        tick(4); mem_rvalid = 1'b1; mem_rdata = 32'hAAAA0000;
        tick(1); mem_rdata = 32'hAAAA0001;
        tick(1); mem_rvalid = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_fill_busy: got %b expected 1", busy); end
        reset = 1'b1;
        tick(1); reset = 1'b0;
        vectors++; if (ram_valid !== 1'b0 || mem_req_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mid_reset_outputs: got rv=%b valid=%b busy=%b expected 0/0/0", ram_valid, mem_req_valid, busy); end
        vectors++; if (ram_data[0] !== 32'h0 || mem_address !== 10'h0) begin miscompares++; $display("FAIL mid_reset_data: got ram_data0=%h addr=%h expected 0/0", ram_data[0], mem_address); end
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD00000;
        tick(1); mem_rdata = 32'hBAD00001;
        tick(1); mem_rvalid = 1'b0;
        tick(3);
        vectors++; if (busy !== 1'b0 || mem_req_valid !== 1'b0 || rv_c.size() != 0) begin miscompares++; $display("FAIL late_rvalid_ignored: got busy=%b valid=%b pulses=%0d expected 0/0/0", busy, mem_req_valid, rv_c.size()); end
        pend.delete();
        auto_resp = 1'b1;
        clear_logs();
        req_address = 10'h040; req_read_en = 1'b1; k = cyc;
        tick(1); req_read_en = 1'b0;
        tick(12);
        for (int i = 0; i < 4; i++) begin
            logic [9:0] ea;
            ea = 10'h040 + 10'(i);
            vectors++; if (xa.size() <= i || xa[i] !== ea) begin miscompares++; $display("FAIL refill_addr[%0d]: got %h expected %h", i, (xa.size() > i) ? xa[i] : 10'h3FF, ea); end
            vectors++; if (rv_d[i] !== 32'h1040 + i) begin miscompares++; $display("FAIL refill_ram_data[%0d]: got %h expected %h", i, rv_d[i], 32'h1040 + i); end
        end
        vectors++; if (rv_c.size() != 1 || rv_c[0] != k + 6) begin miscompares++; $display("FAIL refill_ram_valid: got %0d pulses expected 1 at +6", rv_c.size()); end
    endtask

    task automatic test_write_read_priority();
        int k;
        clear_logs();
        req_address = 10'h200; req_write_data = 32'h0000CAFE;
        req_write_en = 1'b1; req_read_en = 1'b1; k = cyc;
        tick(1); req_write_en = 1'b0; req_address = 10'h305;
        tick(2); req_read_en = 1'b0;
        tick(12);
        vectors++; if (xa.size() != 5) begin miscompares++; $display("FAIL prio_xfer_count: got %0d expected 5", xa.size()); end
        vectors++; if (xa.size() < 1 || xa[0] !== 10'h200 || xw[0] !== 1'b1 || xd[0] !== 32'h0000CAFE || xc[0] != k + 1) begin miscompares++; $display("FAIL prio_write_first: got addr=%h we=%b expected 200 write at +1", (xa.size() > 0) ? xa[0] : 10'h3FF, (xw.size() > 0) ? xw[0] : 1'b0); end
        for (int i = 0; i < 4; i++) begin
            logic [9:0] ea;
            ea = 10'h304 + 10'(i);
            vectors++; if (xa.size() <= i + 1 || xa[i+1] !== ea || xw[i+1] !== 1'b0 || xc[i+1] != k + 3 + i) begin miscompares++; $display("FAIL prio_read[%0d]: got %h expected %h read at +%0d", i, (xa.size() > i + 1) ? xa[i+1] : 10'h3FF, ea, 3 + i); end
            vectors++; if (rv_d[i] !== 32'h1304 + i) begin miscompares++; $display("FAIL prio_ram_data[%0d]: got %h expected %h", i, rv_d[i], 32'h1304 + i); end
        end
        vectors++; if (rv_c.size() != 1 || rv_c[0] != k + 8) begin miscompares++; $display("FAIL prio_ram_valid: got %0d pulses expected 1 at +8", rv_c.size()); end
    endtask

    initial begin
        reset = 1'b1;
        req_address = '0; req_read_en = 1'b0;
        req_write_data = '0; req_write_en = 1'b0;
        mem_req_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        test_reset();
        test_read_fill();
        test_ready_toggle();
        test_write();
        test_held_read();
        test_reset_mid_fill();
        test_write_read_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_block_fill.md
Name: cache_block_fill

Overview:
- Memory-side fill engine directly downstream of the cache.
- Consumes the cache's propagated requests (prop_address, prop_read_en, prop_write_data, prop_write_en).
- On a read miss, fetches the whole aligned block word-by-word from a word-wide memory port, assembles it, and returns it as ram_valid/ram_data.
- On a write, forwards a single-word write to memory.

Parameters:
- RAM_ADDRESS_BITS, 10, width of word address.
- DATA_BITS, 32, word width.
- BLOCK_BITS, 2, log2 of words per block; BLOCK_SIZE = 2**BLOCK_BITS.
- COOLDOWN_CYCLES, 2, cycles after a fill during which new read requests are ignored, so the cache's level-held miss does not refetch.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous reset, active-high.
- req_address  in  RAM_ADDRESS_BITS  request word address (from prop_address).
- req_read_en  in  1  read/fill request, level (from prop_read_en).
- req_write_data  in  DATA_BITS  write word (from prop_write_data).
- req_write_en  in  1  write request, level (from prop_write_en).
- ram_valid  out  1  one-cycle pulse: ram_data holds a complete block.
- ram_data  out  DATA_BITS x BLOCK_SIZE  unpacked array, index = block offset.
- busy  out  1  high in every state except IDLE.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_address  out  RAM_ADDRESS_BITS  memory word address.
- mem_write_en  out  1  1 = write request, 0 = read request.
- mem_write_data  out  DATA_BITS  write word.
- mem_rvalid  in  1  read response valid; responses arrive in request order.
- mem_rdata  in  DATA_BITS  read response word.

Behaviour:
- Reset values: ram_valid=0, ram_data all '0, busy=0, mem_req_valid=0, mem_address='0, mem_write_en=0, mem_write_data='0, state IDLE, both counters 0.
- Memory handshake: a transfer occurs when mem_req_valid & mem_req_ready. While valid and not ready, mem_address, mem_write_en and mem_write_data are held stable. mem_req_valid never drops before a transfer.
- FSM states: IDLE, WRITE, FILL, DONE, COOLDOWN.
- IDLE:
  - req_write_en=1: latch address and data, go to WRITE. Write has priority over a simultaneous read.
  - else req_read_en=1: latch base = req_address with low BLOCK_BITS cleared, clear issue_cnt and recv_cnt, go to FILL.
  - mem_rvalid is ignored in IDLE (stale responses are discarded).
- WRITE:
  - mem_req_valid=1, mem_write_en=1, latched address and data.
  - On transfer, go to IDLE.
  - A read still held high is accepted on the next IDLE cycle.
- FILL:
  - Issue side: while issue_cnt < BLOCK_SIZE, drive mem_req_valid=1, mem_write_en=0, mem_address = base + issue_cnt. Increment issue_cnt on each transfer. Back-to-back issue at one per cycle when ready is high.
  - Receive side: on mem_rvalid, write mem_rdata into buffer[recv_cnt] and increment recv_cnt. Issue and receive may happen in the same cycle.
  - When recv_cnt reaches BLOCK_SIZE, go to DONE.
  - No response before the first issued transfer is required to be handled.
- DONE:
  - ram_valid=1 for exactly one cycle; ram_data = buffer.
  - Go to COOLDOWN.
  - ram_data keeps its value after DONE until the next fill completes.
- COOLDOWN:
  - Count COOLDOWN_CYCLES cycles, then go to IDLE.
  - req_read_en and req_write_en are ignored here. The requester must hold any write until busy=0.
- Widths and arithmetic:
  - Counters are BLOCK_BITS+1 bits wide.
  - Address add is on the offset field only, so it never carries into the index/tag field and never crosses the block.
  - base + issue_cnt wraps mod 2**RAM_ADDRESS_BITS only in that sense.
- Latency: fill with mem_req_ready=1 and 1-cycle response latency gives ram_valid BLOCK_SIZE+2 cycles after the accept cycle.
- Reset mid-operation (any state): next cycle all outputs take their reset values. The partial buffer is cleared. Outstanding responses arriving afterwards are discarded in IDLE.
- Requests whose address changes during FILL are ignored; the latched base is used.

Test Plan:
- Read req 0x0B7, ready=1, rdata=addr+0x1000 one cycle later -> mem_address 0x0B4,0x0B5,0x0B6,0x0B7 on 4 consecutive cycles. ram_valid pulses once, 6 cycles after accept. ram_data = {0x10B4,0x10B5,0x10B6,0x10B7}.
- Same fill with mem_req_ready toggling 0/1 every cycle -> each address held while ready=0. Exactly 4 transfers, no duplicates, same ram_data.
- Write addr 0x123, data 0xDEADBEEF -> one transfer with mem_write_en=1, mem_address 0x123, data 0xDEADBEEF. No ram_valid; busy=0 one cycle after transfer.
- req_read_en held high through DONE and COOLDOWN (COOLDOWN_CYCLES=2), dropped afterwards -> exactly 4 read transfers and a single ram_valid pulse.
- reset asserted after 2 words received -> ram_valid=0, mem_req_valid=0, busy=0 next cycle. Two late mem_rvalid ignored. New read 0x040 fills 0x040..0x043 correctly.
- req_read_en and req_write_en both high in IDLE (write 0x200, read 0x305) -> write transfer to 0x200 first, then reads 0x304..0x307, then ram_valid.
